// File: rtl/fft_ctrl_pkg.sv
// Shared types and register-map constants for the FFT frame scheduler.
// Addresses for CTRL and STATUS are offsets from N_POINT, right after the sample window.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int n_point(input int stages);
    return 1 << stages;
  endfunction

  localparam int ADDR_CTRL_OFS   = 0;
  localparam int ADDR_STATUS_OFS = 1;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR_ERR = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 8;

endpackage

// File: rtl/fft_run_timer.sv
// Loadable down-counter tracking the core pipeline; expire_o flags the edge on which it hits zero.
// Load takes effect on the next edge; free-running decrement, no backpressure.
module fft_run_timer #(
  parameter int unsigned LOAD_VALUE = 10
) (
  input  logic clkk,
  input  logic reset,
  input  logic load_i,
  output logic zero_o,
  output logic expire_o
);

  localparam int CW = $clog2(LOAD_VALUE + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(LOAD_VALUE);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clkk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o   = (cnt_q == '0);
  // Capture happens on the edge that takes the count from 1 to 0.
  assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frame-level sequencer: CPU loads samples, launches the FFT core, captures and serves the results.
// Every CPU access is acked one cycle after its strobe; illegal accesses set a sticky error flag.
module fft_frame_scheduler
  import fft_ctrl_pkg::*;
#(
  parameter int NO_STAGES    = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int CORE_LATENCY = 10
) (
  input  logic                                   clkk,
  input  logic                                   reset,
  input  logic                                   cpu_read,
  input  logic                                   cpu_write,
  input  logic [ADDR_WIDTH-1:0]                  cpu_address,
  input  logic [DATA_WIDTH-1:0]                  cpu_write_data,
  output logic [DATA_WIDTH-1:0]                  cpu_read_data,
  output logic                                   cpu_access_complete,
  output logic [n_point(NO_STAGES)*SAMPLE_WIDTH-1:0] core_x,
  output logic                                   core_start,
  input  logic [n_point(NO_STAGES)*SAMPLE_WIDTH-1:0] core_y,
  output logic                                   busy,
  output logic                                   done_irq,
  output logic                                   error
);

  localparam int N_POINT = n_point(NO_STAGES);
  localparam int FW      = N_POINT * SAMPLE_WIDTH;
  localparam int LCW     = $clog2(N_POINT + 1);

  state_t                  state_q, state_d;
  logic [FW-1:0]           x_q, x_d, y_q, y_d;
  logic [N_POINT-1:0]      mask_q, mask_d;
  logic [LCW-1:0]          cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic                    ack_q, start_q, start_d, irq_q, irq_d;
  logic                    timer_load, timer_zero, timer_expire;
  logic                    is_sample, is_ctrl, is_status;
  logic [NO_STAGES-1:0]    idx;
  logic [15:0]             status;
  logic                    unused_sig;

  fft_run_timer #(.LOAD_VALUE(CORE_LATENCY)) u_timer (
    .clkk     (clkk),
    .reset    (reset),
    .load_i   (timer_load),
    .zero_o   (timer_zero),
    .expire_o (timer_expire)
  );

  assign unused_sig = ^{cpu_write_data, timer_zero};

  assign is_sample = (cpu_address < ADDR_WIDTH'(N_POINT));
  assign is_ctrl   = (cpu_address == ADDR_WIDTH'(N_POINT + ADDR_CTRL_OFS));
  assign is_status = (cpu_address == ADDR_WIDTH'(N_POINT + ADDR_STATUS_OFS));
  assign idx       = cpu_address[NO_STAGES-1:0];

  always_comb begin
    status                            = '0;
    status[ST_BUSY]                   = (state_q == RUN);
    status[ST_DONE]                   = (state_q == DONE);
    status[ST_ERR]                    = err_q;
    status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(cnt_q);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdat_d     = '0;
    start_d    = 1'b0;
    irq_d      = 1'b0;
    timer_load = 1'b0;

    if (state_q == RUN && timer_expire) begin
      y_d     = core_y;
      irq_d   = 1'b1;
      state_d = DONE;
    end

    if (cpu_read && cpu_write) begin
      err_d = 1'b1;
    end else if (cpu_read) begin
      if (is_sample) begin
        if (state_q == DONE)
          rdat_d = DATA_WIDTH'(y_q[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
      end else if (is_status) begin
        rdat_d = DATA_WIDTH'(status);
      end else if (!is_ctrl) begin
        err_d = 1'b1;
      end
    end else if (cpu_write) begin
      if (is_sample) begin
        if (state_q == RUN) begin
          err_d = 1'b1;
        end else begin
          x_d[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] = cpu_write_data[SAMPLE_WIDTH-1:0];
          if (!mask_q[idx]) begin
            mask_d[idx] = 1'b1;
            cnt_d       = cnt_q + LCW'(1);
          end
          state_d = IDLE;
        end
      end else if (is_ctrl) begin
        // Clear first so a combined clear+start reports a failed start.
        if (cpu_write_data[CTRL_CLR_ERR])
          err_d = 1'b0;
        if (cpu_write_data[CTRL_START]) begin
          if (state_q == RUN || cnt_q != LCW'(N_POINT)) begin
            err_d = 1'b1;
          end else begin
            start_d    = 1'b1;
            timer_load = 1'b1;
            mask_d     = '0;
            cnt_d      = '0;
            state_d    = RUN;
          end
        end
      end else if (!is_status) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clkk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      ack_q   <= cpu_read | cpu_write;
      start_q <= start_d;
      irq_q   <= irq_d;
    end
  end

  assign cpu_read_data       = rdat_q;
  assign cpu_access_complete = ack_q;
  assign core_x              = x_q;
  assign core_start          = start_q;
  assign busy                = (state_q == RUN);
  assign done_irq            = irq_q;
  assign error               = err_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: loads frames, times launch/capture, exercises error paths and reset.
module tb_fft_frame_scheduler;

  localparam int N  = 16;
  localparam int SW = 16;
  localparam logic [7:0] A_CTRL   = 8'd16;
  localparam logic [7:0] A_STATUS = 8'd17;

  logic          clkk = 1'b0;
  logic          reset;
  logic          cpu_read, cpu_write;
  logic [7:0]    cpu_address;
  logic [31:0]   cpu_write_data;
  logic [31:0]   cpu_read_data;
  logic          cpu_access_complete;
  logic [N*SW-1:0] core_x, core_y;
  logic          core_start, busy, done_irq, error;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  fft_frame_scheduler dut (
    .clkk                (clkk),
    .reset               (reset),
    .cpu_read            (cpu_read),
    .cpu_write           (cpu_write),
    .cpu_address         (cpu_address),
    .cpu_write_data      (cpu_write_data),
    .cpu_read_data       (cpu_read_data),
    .cpu_access_complete (cpu_access_complete),
    .core_x              (core_x),
    .core_start          (core_start),
    .core_y              (core_y),
    .busy                (busy),
    .done_irq            (done_irq),
    .error               (error)
  );

  always #5 clkk = ~clkk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
    cpu_address = a; cpu_write_data = d; cpu_write = 1'b1;
    @(posedge clkk); #1;
    cpu_write = 1'b0;
    chk("wr_ack", 32'(cpu_access_complete), 32'd1);
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d);
    cpu_address = a; cpu_read = 1'b1;
    @(posedge clkk); #1;
    cpu_read = 1'b0;
    chk("rd_ack", 32'(cpu_access_complete), 32'd1);
    d = cpu_read_data;
  endtask

  // Launch a full frame and step 12 cycles; core_y is only valid in the cycle before the expected capture edge.
  task automatic run_frame(input int inj_c, input int rst_c, input logic [15:0] ybase,
                           input logic [15:0] x5_exp);
    int irq_cnt = 0;
    core_y = {N{16'hEEEE}};
    cpu_wr(A_CTRL, 32'd1);
    chk("start_pulse", 32'(core_start), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    for (int c = 1; c <= 12; c++) begin
      if (c == 10)
        for (int i = 0; i < N; i++) core_y[i*SW +: SW] = ybase + 16'(i);
      if (c == inj_c) begin
        cpu_address = 8'd5; cpu_write_data = 32'hBEEF; cpu_write = 1'b1;
      end
      if (c == rst_c) reset = 1'b1;
      @(posedge clkk); #1;
      cpu_write = 1'b0;
      reset     = 1'b0;
      core_y    = {N{16'hEEEE}};
      if (done_irq) irq_cnt++;
      if (c == 1) chk("start_one_cycle", 32'(core_start), 32'd0);
      if (c == inj_c) begin
        chk("inj_ack", 32'(cpu_access_complete), 32'd1);
        chk("inj_err", 32'(error), 32'd1);
        chk("inj_x5", 32'(core_x[95:80]), 32'(x5_exp));
      end
      if (c == rst_c) begin
        chk("rst_ack", 32'(cpu_access_complete), 32'd0);
        chk("rst_rdat", cpu_read_data, 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(done_irq), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_core_x", 32'(|core_x), 32'd0);
      end
      if (rst_c == 0 && c == 9) chk("busy_c9", 32'(busy), 32'd1);
      if (rst_c == 0 && c == 10) chk("irq_at_10", 32'(done_irq), 32'd1);
    end
    chk("irq_count", 32'(irq_cnt), (rst_c == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_write_data = '0; core_y = '0;
    repeat (2) @(posedge clkk);
    #1 reset = 1'b0;

    chk("por_ack", 32'(cpu_access_complete), 32'd0);
    chk("por_start", 32'(core_start), 32'd0);
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_irq", 32'(done_irq), 32'd0);
    chk("por_err", 32'(error), 32'd0);
    chk("por_core_x", 32'(|core_x), 32'd0);
    cpu_rd(A_STATUS, rd); chk("por_status", rd, 32'h0000);

    // Frame 1: sample value = index.
    for (int i = 0; i < N; i++) cpu_wr(8'(i), 32'(i));
    chk("x3_loaded", 32'(core_x[3*SW +: SW]), 32'd3);
    cpu_rd(A_STATUS, rd); chk("status_full", rd, 32'h1000);
    cpu_rd(A_CTRL, rd);   chk("ctrl_read_zero", rd, 32'h0);
    run_frame(0, 0, 16'hC000, 16'h0005);
    chk("busy_after_done", 32'(busy), 32'd0);
    cpu_rd(A_STATUS, rd); chk("status_done", rd, 32'h0002);
    cpu_rd(8'd3, rd);     chk("y3_frame1", rd, 32'h0000_C003);

    // Leave DONE via a sample write; results now read as zero.
    cpu_wr(8'd0, 32'h55);
    cpu_rd(8'd0, rd);     chk("y0_after_leave", rd, 32'h0);
    cpu_rd(A_STATUS, rd); chk("status_cnt1", rd, 32'h0100);
    for (int i = 1; i < 15; i++) cpu_wr(8'(i), 32'h100 + 32'(i));
    cpu_wr(8'd0, 32'h55);
    cpu_wr(A_CTRL, 32'd1);
    chk("partial_no_start", 32'(core_start), 32'd0);
    chk("partial_err", 32'(error), 32'd1);
    cpu_rd(A_STATUS, rd); chk("status_partial", rd, 32'h0F04);
    cpu_wr(A_CTRL, 32'd2);
    cpu_rd(A_STATUS, rd); chk("status_cleared", rd, 32'h0F00);
    cpu_wr(8'd15, 32'h10F);
    cpu_rd(A_STATUS, rd); chk("status_refull", rd, 32'h1000);

    // Frame 2 with an illegal SAMPLE[5] write mid-run.
    run_frame(3, 0, 16'hD000, 16'h0105);
    chk("x5_held", 32'(core_x[95:80]), 32'h105);
    cpu_rd(8'd7, rd);     chk("y7_frame2", rd, 32'h0000_D007);
    cpu_rd(A_STATUS, rd); chk("status_done_err", rd, 32'h0006);
    cpu_wr(A_CTRL, 32'd2);
    chk("err_cleared", 32'(error), 32'd0);

    // Simultaneous strobes: one ack, no write, error.
    cpu_address = 8'd0; cpu_write_data = 32'h1234; cpu_read = 1'b1; cpu_write = 1'b1;
    @(posedge clkk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    chk("both_ack", 32'(cpu_access_complete), 32'd1);
    chk("both_err", 32'(error), 32'd1);
    @(posedge clkk); #1;
    chk("both_single_ack", 32'(cpu_access_complete), 32'd0);
    chk("both_x0", 32'(core_x[SW-1:0]), 32'h55);
    cpu_wr(A_CTRL, 32'd2);
    cpu_wr(A_STATUS, 32'hFF);
    chk("status_wr_no_err", 32'(error), 32'd0);
    cpu_rd(8'h40, rd);
    chk("bad_addr_rdat", rd, 32'h0);
    chk("bad_addr_err", 32'(error), 32'd1);

    // Frame 3 abandoned by reset at run cycle 5.
    for (int i = 0; i < N; i++) cpu_wr(8'(i), 32'(i));
    run_frame(0, 5, 16'hA000, 16'h0005);
    cpu_rd(A_STATUS, rd); chk("status_after_rst", rd, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
Single-clock sequencer that owns one fft_n_point_core instance. It collects N_POINT samples from CPU register writes into an input frame and launches the core with a one-cycle start pulse. It tracks the core's fixed pipeline latency, captures the output frame, and serves results back to the CPU with status, error and completion reporting. It replaces the FIFO-and-shift-register glue around the core with an explicit frame-level FSM.

Parameters:
NO_STAGES, 4, log2 of FFT size; N_POINT = 2**NO_STAGES
SAMPLE_WIDTH, 16, width of one core sample
DATA_WIDTH, 32, CPU data width; must be >= SAMPLE_WIDTH
ADDR_WIDTH, 8, CPU word-address width; must be > NO_STAGES
CORE_LATENCY, 10, cycles from core_start to a valid core_y; range 1..255

Ports:
clkk  in  1  clock
reset  in  1  synchronous, active-high
cpu_read  in  1  read strobe, one cycle per access
cpu_write  in  1  write strobe, one cycle per access
cpu_address  in  ADDR_WIDTH  word address
cpu_write_data  in  DATA_WIDTH  write data
cpu_read_data  out  DATA_WIDTH  read data, valid with cpu_access_complete
cpu_access_complete  out  1  one-cycle ack per access
core_x  out  N_POINT*SAMPLE_WIDTH  input frame; sample i occupies bits [i*SW +: SW]
core_start  out  1  one-cycle launch pulse
core_y  in  N_POINT*SAMPLE_WIDTH  core output frame
busy  out  1  high in RUN
done_irq  out  1  one-cycle pulse when results are captured
error  out  1  sticky error flag

Behaviour:
- Reset: rising clkk with reset=1 clears every output to 0, the FSM to IDLE, and load_mask, load_cnt, run counter and result buffer to 0. Reset during RUN abandons the frame; later core_y values are ignored.
- Register map (word address):
  - 0..N_POINT-1: SAMPLE[i]. A write stores wdata[SAMPLE_WIDTH-1:0] in x[i]. A read returns y[i] zero-extended in DONE, else 0.
  - N_POINT: CTRL, write-only. Bit0 = start, bit1 = clear_error. A read returns 0.
  - N_POINT+1: STATUS, read-only. Bit0 busy, bit1 done, bit2 error, bits[15:8] load_cnt. A write to STATUS is ignored without error.
  - Any other address: access ignored, error set, read data 0.
- Ack timing: cpu_access_complete is asserted exactly 1 cycle after every strobe cycle; cpu_read_data is registered alongside it.
- Simultaneous strobes: cpu_read and cpu_write in the same cycle give one ack, no access performed, error set.
- load_mask[N_POINT] records which sample indices have been written. load_cnt increments only on a write to an unset index, so rewriting a loaded index does not advance it.
- FSM states: IDLE, RUN, DONE.
  - IDLE, sample write: accepted.
  - IDLE, start with load_cnt==N_POINT: core_start=1 for the next cycle, core_x is held stable from the input registers, load_mask and load_cnt clear, run counter loads CORE_LATENCY, go to RUN.
  - IDLE, start with load_cnt<N_POINT: error set, remain in IDLE.
  - RUN, counting: busy=1; the counter decrements each cycle.
  - RUN, counter reaches 0: core_y is captured into the result buffer, done_irq pulses for 1 cycle, go to DONE. A core_start pulse at cycle t gives capture at cycle t+CORE_LATENCY.
  - RUN, any sample write or start: ignored, error set. core_x must not change during RUN.
  - DONE, results: readable; done status bit = 1.
  - DONE, sample write: accepted, go to IDLE, done cleared, results reading as 0.
  - DONE, start with a full frame: behaves as from IDLE. Start with a partial frame sets error and leaves the state unchanged.
- Error handling: error is sticky until a CTRL write with bit1=1. If that same write also sets start, the start is evaluated after the clear.
- Start edge case: CTRL bit0 combined with a sample write is impossible, since only one address is accessed per cycle.

Decomposition:
- Package fft_ctrl_pkg:
  - state_t enum {IDLE, RUN, DONE}
  - N_POINT function of NO_STAGES
  - ADDR_CTRL and ADDR_STATUS offsets
  - CTRL bit indices and STATUS field positions
- Sub-module fft_run_timer: loadable down-counter with load/zero outputs, width $clog2(CORE_LATENCY+1). Everything else, including the FSM, register file and result buffer, stays in the top module.

Test Plan (defaults; N_POINT=16, CORE_LATENCY=10):
- Load 16 samples with value = index, write CTRL=1 -> core_start is high exactly 1 cycle; busy=1; done_irq fires 10 cycles after core_start; STATUS reads 0x0002; SAMPLE[3] returns the driven core_y[3].
- Load 15 distinct samples plus a rewrite of index 0, then start -> no core_start, error=1, STATUS reads 0x0F04; CTRL=2 clears it to 0x0F00.
- Write SAMPLE[5] during RUN -> ignored, error=1, core_x bits [95:80] unchanged, capture still occurs at t+10.
- Assert cpu_read and cpu_write together on address 0 -> single ack, x[0] unchanged, error=1. A read of address 0x40 -> read data 0, error=1.
- Apply reset at RUN cycle 5 -> all outputs 0 the next cycle, no done_irq afterwards, STATUS reads 0x0000.
- In DONE, write SAMPLE[0] -> state IDLE, SAMPLE[0] read returns 0, load_cnt=1; refill the frame and start -> second frame completes normally.
